spi_frame_fsm: RTL and testbench

Protocol stage directly downstream of the input conditioners on the SPI pins. It consumes the conditioned chip-select and MOSI levels and the one-cycle SCLK edge pulses, and decodes each frame as an address, an R/W bit, then one data word. It drives a simple synchronous memory port and the MISO pin, so reads and writes to the on-chip memory are serviced entirely in the system clock domain.

---
 rtl/spi_frame_fsm.sv | 169 ++++++++++++++++
 tb/tb_spi_frame_fsm.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_fsm.sv
// SPI frame decoder: address, R/W bit, then one data word, serviced on a simple
// synchronous memory port entirely in the system clock domain.
module spi_frame_fsm #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cs_cond,
    input  logic                  mosi_cond,
    input  logic                  sclk_posedge,
    input  logic                  sclk_negedge,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  miso,
    output logic                  miso_oe,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int unsigned MAX_BITS = ((ADDR_WIDTH + 1) > DATA_WIDTH) ? (ADDR_WIDTH + 1) : DATA_WIDTH;
    localparam int unsigned CNT_W    = $clog2(MAX_BITS) + 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        LOAD,
        READ,
        WRITE,
        COMMIT,
        DONE
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr_sr;
    logic [DATA_WIDTH-1:0] r_tx;

    // Gated by miso_oe so the pin reads 0 whenever it is not driven.
    assign miso = miso_oe & r_tx[DATA_WIDTH-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr_sr   <= '0;
            r_tx        <= '0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            miso_oe     <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            mem_wr_en  <= 1'b0;
            frame_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!cs_cond) begin
                        r_state   <= GET_ADDR;
                        r_cnt     <= '0;
                        r_addr_sr <= '0;
                        busy      <= 1'b1;
                    end
                end

                GET_ADDR: begin
                    if (cs_cond) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        miso_oe <= 1'b0;
                    end else if (sclk_posedge) begin
                        // The final posedge carries the R/W bit; the address is already complete.
                        if (r_cnt == ADDR_LAST) begin
                            mem_addr <= r_addr_sr;
                            r_cnt    <= '0;
                            r_state  <= mosi_cond ? LOAD : WRITE;
                        end else begin
                            r_addr_sr <= (r_addr_sr << 1) | ADDR_WIDTH'(mosi_cond);
                            r_cnt     <= r_cnt + 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (cs_cond) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        miso_oe <= 1'b0;
                    end else if (sclk_negedge) begin
                        r_tx    <= mem_rd_data;
                        miso_oe <= 1'b1;
                        r_state <= READ;
                    end
                end

                READ: begin
                    if (cs_cond) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        miso_oe <= 1'b0;
                    end else begin
                        if (sclk_negedge) begin
                            r_tx <= r_tx << 1;
                        end
                        if (sclk_posedge) begin
                            if (r_cnt == DATA_LAST) begin
                                r_cnt      <= '0;
                                r_state    <= DONE;
                                miso_oe    <= 1'b0;
                                frame_done <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                end

                WRITE: begin
                    if (cs_cond) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        miso_oe <= 1'b0;
                    end else if (sclk_posedge) begin
                        mem_wr_data <= (mem_wr_data << 1) | DATA_WIDTH'(mosi_cond);
                        if (r_cnt == DATA_LAST) begin
                            r_cnt     <= '0;
                            r_state   <= COMMIT;
                            mem_wr_en <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                COMMIT: begin
                    // The write strobe is already on the port; a late deassert only drops frame_done.
                    if (cs_cond) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state    <= DONE;
                        frame_done <= 1'b1;
                    end
                end

                DONE: begin
                    miso_oe <= 1'b0;
                    if (cs_cond) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    miso_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_fsm.sv
// Randomized frame-level bench for spi_frame_fsm against a memory-array reference model.
module tb_spi_frame_fsm;

    localparam int AW = 7;
    localparam int DW = 8;

    logic          clk          = 1'b0;
    logic          reset_n      = 1'b0;
    logic          cs_cond      = 1'b1;
    logic          mosi_cond    = 1'b0;
    logic          sclk_posedge = 1'b0;
    logic          sclk_negedge = 1'b0;
    logic [DW-1:0] mem_rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wr_data;
    logic          miso;
    logic          miso_oe;
    logic          frame_done;
    logic          busy;

    logic [DW-1:0] dev_mem [2**AW] = '{default: '0};
    logic [DW-1:0] ref_mem [2**AW] = '{default: '0};

    int            n_checks = 0;
    int            n_fail   = 0;
    int            wr_cnt   = 0;
    int            fd_cnt   = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;

    always #5 clk = ~clk;

    assign mem_rd_data = dev_mem[mem_addr];

    spi_frame_fsm #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cs_cond      (cs_cond),
        .mosi_cond    (mosi_cond),
        .sclk_posedge (sclk_posedge),
        .sclk_negedge (sclk_negedge),
        .mem_rd_data  (mem_rd_data),
        .mem_addr     (mem_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    // Memory device and strobe counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_cnt++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wr_data;
            dev_mem[mem_addr] = mem_wr_data;
        end
        if (frame_done) fd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clkn(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCLK period: rising edge (master samples MISO), then falling edge.
    task automatic bit_cycle(input logic b, output logic s, output logic oe);
        mosi_cond = b;
        clkn(1);
        sclk_posedge = 1'b1;
        s  = miso;
        oe = miso_oe;
        clkn(1);
        sclk_posedge = 1'b0;
        clkn(1);
        sclk_negedge = 1'b1;
        clkn(1);
        sclk_negedge = 1'b0;
    endtask

    task automatic run_frame(input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] d,
                             input int abort_at, input int gap);
        int            wr0;
        int            fd0;
        logic          s;
        logic          oe;
        logic [DW-1:0] got;
        bit            complete;
        wr0      = wr_cnt;
        fd0      = fd_cnt;
        got      = '0;
        complete = (abort_at >= DW);
        cs_cond  = 1'b0;
        clkn(2);
        check_eq("busy_in_frame", 32'(busy), 32'd1);
        for (int i = AW - 1; i >= 0; i--) begin
            bit_cycle(a[i], s, oe);
            check_eq("oe_addr", 32'(oe), 32'd0);
        end
        bit_cycle(rw, s, oe);
        check_eq("oe_rw", 32'(oe), 32'd0);
        for (int i = 0; i < DW; i++) begin
            if (i == abort_at) break;
            bit_cycle(rw ? 1'($urandom) : d[DW-1-i], s, oe);
            check_eq(rw ? "oe_read" : "oe_write", 32'(oe), 32'(rw));
            if (rw) got = {got[DW-2:0], s};
        end
        cs_cond = 1'b1;
        clkn(1);
        check_eq("busy_after_cs", 32'(busy), 32'd0);
        check_eq("oe_after_cs", 32'(miso_oe), 32'd0);
        check_eq("miso_after_cs", 32'(miso), 32'd0);
        check_eq("mem_addr_held", 32'(mem_addr), 32'(a));
        if (complete) begin
            check_eq("frame_done_cnt", 32'(fd_cnt - fd0), 32'd1);
            if (rw) begin
                check_eq("read_data", 32'(got), 32'(ref_mem[a]));
                check_eq("wr_cnt_read", 32'(wr_cnt - wr0), 32'd0);
            end else begin
                check_eq("wr_cnt", 32'(wr_cnt - wr0), 32'd1);
                check_eq("wr_addr", 32'(last_wr_addr), 32'(a));
                check_eq("wr_data", 32'(last_wr_data), 32'(d));
                ref_mem[a] = d;
            end
        end else begin
            check_eq("abort_frame_done", 32'(fd_cnt - fd0), 32'd0);
            check_eq("abort_wr_cnt", 32'(wr_cnt - wr0), 32'd0);
        end
        if (gap > 1) clkn(gap - 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic          s;
        logic          oe;
        int            wr0;
        logic [AW-1:0] ra;
        logic          rrw;
        logic [DW-1:0] rd;
        int            rab;

        clkn(3);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check_eq("rst_wr_data", 32'(mem_wr_data), 32'd0);
        check_eq("rst_miso", 32'(miso), 32'd0);
        check_eq("rst_miso_oe", 32'(miso_oe), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        clkn(2);

        run_frame(7'h15, 1'b0, 8'h3C, 99, 2);
        run_frame(7'h15, 1'b1, 8'h00, 99, 1);
        run_frame(7'h15, 1'b0, 8'hA5, 99, 1);
        run_frame(7'h15, 1'b1, 8'h00, 99, 1);

        run_frame(7'h22, 1'b0, 8'h5A, 4, 2);
        run_frame(7'h22, 1'b0, 8'h66, 99, 2);
        run_frame(7'h22, 1'b1, 8'h00, 99, 2);

        cs_cond = 1'b1;
        wr0 = wr_cnt;
        for (int i = 0; i < 20; i++) begin
            mosi_cond = 1'($urandom);
            clkn(1);
            sclk_posedge = 1'b1;
            sclk_negedge = 1'($urandom);
            clkn(1);
            sclk_posedge = 1'b0;
            sclk_negedge = 1'b0;
            check_eq("noise_busy", 32'(busy), 32'd0);
            check_eq("noise_oe", 32'(miso_oe), 32'd0);
        end
        check_eq("noise_wr_cnt", 32'(wr_cnt - wr0), 32'd0);

        run_frame(7'h2A, 1'b0, 8'hFF, 99, 2);
        cs_cond = 1'b0;
        clkn(2);
        for (int i = AW - 1; i >= 0; i--) begin
            bit_cycle(1'(7'h2A >> i), s, oe);
        end
        bit_cycle(1'b1, s, oe);
        for (int i = 0; i < 3; i++) bit_cycle(1'b0, s, oe);
        check_eq("mid_read_oe", 32'(miso_oe), 32'd1);
        check_eq("mid_read_miso", 32'(miso), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_oe", 32'(miso_oe), 32'd0);
        check_eq("async_rst_miso", 32'(miso), 32'd0);
        check_eq("async_rst_busy", 32'(busy), 32'd0);
        check_eq("async_rst_addr", 32'(mem_addr), 32'd0);
        cs_cond = 1'b1;
        clkn(2);
        reset_n = 1'b1;
        clkn(2);

        for (int n = 0; n < 40; n++) begin
            ra  = AW'($urandom_range(0, 15));
            rrw = 1'($urandom_range(0, 1));
            rd  = DW'($urandom);
            rab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DW - 1)) : 99;
            run_frame(ra, rrw, rd, rab, int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
